// File: rtl/ff_arb_pkg.sv
// Shared types and helpers for the round-robin shared-register arbiter.
// Owner indices are at least one bit wide.
package ff_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ff_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping modulo N_REQ.
module rr_pick
  import ff_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int W     = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [W-1:0]     i_ptr,
  output logic             o_found,
  output logic [W-1:0]     o_idx
);

  logic [W-1:0] w_cand;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_cand = W'((int'(i_ptr) + i) % N_REQ);
      if (!o_found && i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/ff_share_arb.sv
// Shared register written by one owner at a time; round-robin grants with an
// optional lock that holds ownership for up to MAX_HOLD cycles.
module ff_share_arb
  import ff_arb_pkg::*;
#(
  parameter  int SIZE     = 1,
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 4,
  localparam int W        = idx_width(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_i,
  input  logic [N_REQ-1:0]      lock_i,
  input  logic [N_REQ*SIZE-1:0] wdata_i,
  output logic [N_REQ-1:0]      gnt_o,
  output logic [W-1:0]          owner_o,
  output logic                  busy_o,
  output logic [SIZE-1:0]       data_o
);

  state_t           r_state;
  logic [W-1:0]     r_owner;
  logic [W-1:0]     r_rr_ptr;
  logic [N_REQ-1:0] r_gnt;
  logic [7:0]       r_hold;
  logic [SIZE-1:0]  r_data;

  logic [SIZE-1:0]  w_wdata [N_REQ];
  logic [W-1:0]     w_next_ptr;
  logic [W-1:0]     w_ptr;
  logic [W-1:0]     w_pick_idx;
  logic             w_found;
  logic             w_own_req;
  logic             w_keep;
  logic [N_REQ-1:0] w_onehot;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign w_wdata[gi] = wdata_i[gi*SIZE +: SIZE];
    end
  endgenerate

  assign w_next_ptr = (r_owner == W'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
  // On release the search already starts from the updated pointer.
  assign w_ptr      = (r_state == OWN) ? w_next_ptr : r_rr_ptr;
  assign w_own_req  = req_i[r_owner];
  assign w_keep     = w_own_req && lock_i[r_owner] && (r_hold < 8'(MAX_HOLD - 1));
  assign w_onehot   = N_REQ'(1) << w_pick_idx;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (req_i),
    .i_ptr   (w_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_gnt    <= '0;
      r_hold   <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= OWN;
            r_owner <= w_pick_idx;
            r_gnt   <= w_onehot;
            r_hold  <= '0;
          end
        end
        OWN: begin
          if (w_own_req) begin
            r_data <= w_wdata[r_owner];
          end
          if (w_keep) begin
            r_hold <= r_hold + 8'd1;
          end else begin
            r_rr_ptr <= w_next_ptr;
            r_hold   <= '0;
            if (w_found) begin
              r_owner <= w_pick_idx;
              r_gnt   <= w_onehot;
            end else begin
              r_state <= IDLE;
              r_gnt   <= '0;
            end
          end
        end
      endcase
    end
  end

  assign gnt_o   = r_gnt;
  assign owner_o = r_owner;
  assign busy_o  = (r_state == OWN);
  assign data_o  = r_data;

endmodule

// File: doc/ff_share_arb.md
FF_SHARE_ARB -- requirements
Module: ff_share_arb

Interface
REQ-001 SHALL have parameter SIZE, default 1, width of the shared register.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter MAX_HOLD, default 4, maximum consecutive owned cycles per grant (1..255).
REQ-004 SHALL use a single clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_i  input  N_REQ  per-requester write request.
REQ-008 lock_i  input  N_REQ  per-requester ownership-hold request, burst mode.
REQ-009 wdata_i  input  N_REQ*SIZE  packed write data; requester k occupies bits [k*SIZE +: SIZE].
REQ-010 gnt_o  output  N_REQ  registered one-hot grant, all-zero when idle.
REQ-011 owner_o  output  clog2(N_REQ)  index of the current owner, valid while busy_o is 1.
REQ-012 busy_o  output  1  high in state OWN.
REQ-013 data_o  output  SIZE  shared register contents.

Function
REQ-014 SHALL implement a two-state FSM, IDLE and OWN; busy_o SHALL be 1 exactly in OWN.
REQ-015 In IDLE, at a rising edge with any req_i bit high: select the first set bit searching from rr_ptr upward with wrap; load owner_o and gnt_o; clear the hold counter; enter OWN. The grant appears 1 cycle after the request; no write occurs on this edge.
REQ-016 In OWN, at an edge with req_i[owner] high: data_o SHALL load wdata_i of the owner, which becomes visible the next cycle.
REQ-017 In OWN, the grant SHALL be retained only if req_i[owner] and lock_i[owner] are both high and the hold counter is below MAX_HOLD-1; the hold counter SHALL then increment by 1.
REQ-018 Otherwise the grant SHALL be released at that edge, and rr_ptr SHALL become (owner+1) mod N_REQ.
REQ-019 On release, if any req_i bit is high, the FSM SHALL regrant the same edge using the updated rr_ptr search, staying in OWN with the hold counter cleared. This gives back-to-back ownership and the same requester may win again if it is the only requester.
REQ-020 On release with no request pending, the FSM SHALL return to IDLE, with gnt_o all zero.
REQ-021 If the owner drops req_i while in OWN, the grant SHALL be released with no write, per REQ-018/019.
REQ-022 req_i/lock_i of non-owners SHALL never affect data_o.
REQ-023 A grant SHALL last at most MAX_HOLD cycles, and every requester holding req_i SHALL be granted within (N_REQ-1)*MAX_HOLD+1 cycles (no starvation).
REQ-024 rr_ptr wrap SHALL be modulo N_REQ, with N_REQ non-power-of-2 supported.
REQ-025 data_o SHALL hold its value when no write occurs.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, gnt_o 0, owner_o 0, busy_o 0, rr_ptr 0, hold counter 0, data_o 0.
REQ-027 Reset asserted mid-burst SHALL abort ownership, with no write on any edge while rst_n is low.
REQ-028 The first grant after reset SHALL honor priority starting at requester 0.

Structure
REQ-029 Package ff_arb_pkg SHALL hold the state enum (IDLE, OWN) and the helper function for clog2 width.
REQ-030 Sub-module rr_pick SHALL be combinational: inputs req vector and pointer; outputs a found flag and the index.
REQ-031 All outputs SHALL be registered.

Verification (SIZE=8, N_REQ=4, MAX_HOLD=4)
REQ-032 Reset: assert rst_n=0 mid-burst -> all outputs 0 within the same cycle, and data_o stays 0 until the first post-reset write.
REQ-033 Single write: req_i=0010, lock=0, wdata1=0xA5 -> gnt_o=0010 one cycle later, data_o=0xA5 the next cycle, then IDLE.
REQ-034 Round-robin: req_i=1111 held, lock=0 -> grant order 0,1,2,3,0 on consecutive owned cycles.
REQ-035 Burst cap: req_i=0001 and lock=0001 held, with 0100 also requesting -> requester 0 owns exactly 4 cycles (4 writes), then requester 2 is granted with no idle cycle.
REQ-036 Owner drop: owner 3 deasserts req mid-lock -> release with no write; data_o unchanged; rr_ptr=0.
REQ-037 Non-owner isolation: non-owner wdata toggles throughout -> data_o reflects only owner writes.
